// File: rtl/ioctl_sdram_packer.sv
// ioctl_sdram_packer
//   Packs the byte-wide ioctl download stream into 16-bit SDRAM words with
//   byte enables. Even/odd bytes of the same word are merged. Lone bytes
//   are written with a single byte enable. Words queue in a small ring FIFO
//   that feeds a level-request / ack-pulse memory port.
//
// Ports
//   clk_sys        system clock, all logic on its rising edge
//   reset          synchronous active-high reset
//   ioctl_download high while a download is active (edges start/end it)
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address of ioctl_dout
//   ioctl_dout     download byte
//   mem_req        word at FIFO head is valid (registered not-empty)
//   mem_addr       word address (byte address [24:1])
//   mem_wdata      even byte in [7:0], odd byte in [15:8]
//   mem_be         byte enables, [0] even byte, [1] odd byte
//   mem_ack        one-cycle pulse, head word written
//   ioctl_wait     high when the FIFO has at most one free entry
//   busy           high from download start until done
//   done           one-cycle completion pulse
//   overflow       sticky, a word was dropped on a full FIFO
//   byte_count     accepted strobes in the current download
module ioctl_sdram_packer #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    output logic        ioctl_wait,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [24:0] byte_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int ENT_W = 24 + 16 + 2;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] WAIT_CNT = FULL_CNT - 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                dl_prev;
    logic                dl_rise;
    logic                accept_wr;
    logic                latch_held;
    logic [24:0]         held_addr;
    logic [7:0]          held_byte;

    logic                push_vld_p0;
    logic [ENT_W-1:0]    push_ent_p0;

    logic [ENT_W-1:0]    fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW-1:0]  rd_ptr_nxt;
    logic [FIFO_AW:0]    count;
    logic [FIFO_AW:0]    count_nxt;
    logic [FIFO_AW:0]    inc_w;
    logic [FIFO_AW:0]    dec_w;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                drop;
    logic [ENT_W-1:0]    head_nxt;

    function automatic logic [ENT_W-1:0] pack_word(input logic [23:0] waddr,
                                                   input logic [15:0] wdata,
                                                   input logic [1:0]  be);
        return {waddr, wdata, be};
    endfunction

    // Stage p0: packer decode, decides this cycle's push and next state
    always_comb begin
        dl_rise     = ioctl_download && !dl_prev;
        accept_wr   = ioctl_wr && busy;
        push_vld_p0 = 1'b0;
        push_ent_p0 = '0;
        latch_held  = 1'b0;
        state_nxt   = state;
        if (dl_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // busy with download low means the download has ended
                    if (busy && !ioctl_download) begin
                        state_nxt = DRAIN;
                    end else if (accept_wr) begin
                        if (!ioctl_addr[0]) begin
                            latch_held = 1'b1;
                            state_nxt  = HALF;
                        end else begin
                            push_vld_p0 = 1'b1;
                            push_ent_p0 = pack_word(ioctl_addr[24:1], {ioctl_dout, 8'h00}, 2'b10);
                        end
                    end
                end
                HALF: begin
                    if (!ioctl_download) begin
                        push_vld_p0 = 1'b1;
                        push_ent_p0 = pack_word(held_addr[24:1], {8'h00, held_byte}, 2'b01);
                        state_nxt   = DRAIN;
                    end else if (accept_wr) begin
                        push_vld_p0 = 1'b1;
                        if (ioctl_addr == held_addr + 25'd1) begin
                            push_ent_p0 = pack_word(held_addr[24:1], {ioctl_dout, held_byte}, 2'b11);
                            state_nxt   = IDLE;
                        end else begin
                            // flush the held even byte; the new byte is kept
                            // either as the next even byte or for FLUSH
                            push_ent_p0 = pack_word(held_addr[24:1], {8'h00, held_byte}, 2'b01);
                            latch_held  = 1'b1;
                            state_nxt   = ioctl_addr[0] ? FLUSH : HALF;
                        end
                    end
                end
                FLUSH: begin
                    push_vld_p0 = 1'b1;
                    push_ent_p0 = pack_word(held_addr[24:1], {held_byte, 8'h00}, 2'b10);
                    state_nxt   = IDLE;
                end
                DRAIN: begin
                    if (count == '0) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; the head word is computed for the next cycle so the
    // memory port outputs can be registered
    always_comb begin
        pop        = mem_ack && mem_req;
        full       = (count == FULL_CNT);
        push_ok    = push_vld_p0 && (!full || pop);
        drop       = push_vld_p0 && full && !pop;
        inc_w      = {{FIFO_AW{1'b0}}, push_ok};
        dec_w      = {{FIFO_AW{1'b0}}, pop};
        count_nxt  = count + inc_w - dec_w;
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        // a push landing in the slot that becomes head bypasses the array
        if (push_ok && (rd_ptr_nxt == wr_ptr)) head_nxt = push_ent_p0;
        else                                   head_nxt = fifo_mem[rd_ptr_nxt];
    end

    // Stage p1: registered control, FIFO pointers and memory port
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_prev    <= ioctl_download;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            state   <= state_nxt;
            dl_prev <= ioctl_download;
            done    <= 1'b0;
            if (dl_rise) begin
                busy       <= 1'b1;
                byte_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (accept_wr) byte_count <= byte_count + 25'd1;
                if (drop)      overflow   <= 1'b1;
                if (state == DRAIN && count == '0) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            mem_req    <= (count_nxt != '0);
            ioctl_wait <= (count_nxt >= WAIT_CNT);
            if (count_nxt != '0) begin
                mem_addr  <= head_nxt[ENT_W-1:18];
                mem_wdata <= head_nxt[17:2];
                mem_be    <= head_nxt[1:0];
            end
        end
    end

    // Data-only registers: held byte and FIFO storage
    always_ff @(posedge clk_sys) begin
        if (latch_held) begin
            held_addr <= ioctl_addr;
            held_byte <= ioctl_dout;
        end
        if (push_ok) fifo_mem[wr_ptr] <= push_ent_p0;
    end

endmodule

// File: tb/tb_ioctl_sdram_packer.sv
// Bench for ioctl_sdram_packer: directed scenarios plus randomized downloads
// checked against a byte-pairing reference model and an in-order list of
// words seen on the memory port.
module tb_ioctl_sdram_packer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic        ioctl_wait;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [24:0] byte_count;

    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    bit          auto_en = 1'b0;
    int          ack_max = 0;

    assign mem_ack = auto_ack | man_ack;

    always #5 clk_sys = ~clk_sys;

    ioctl_sdram_packer #(.FIFO_AW(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .ioctl_wait(ioctl_wait),
        .busy(busy), .done(done), .overflow(overflow), .byte_count(byte_count)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [41:0] exp_q[$];
    logic [41:0] rx_q[$];
    logic [24:0] s_addr[$];
    logic [7:0]  s_data[$];

    // Memory-side responder: acks the head word after a random delay and
    // logs every word it acknowledges.
    initial begin : responder
        int ack_wait;
        ack_wait = 0;
        forever begin
            @(posedge clk_sys);
            #2;
            auto_ack = 1'b0;
            if (auto_en && mem_req) begin
                if (ack_wait == 0) begin
                    auto_ack = 1'b1;
                    rx_q.push_back({mem_addr, mem_wdata, mem_be});
                    ack_wait = $urandom_range(0, ack_max);
                end else begin
                    ack_wait--;
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference: pair bytes into words from the strobe list using the
    // even/odd merging rules, in strobe order.
    task automatic model_words();
        bit          pend;
        logic [24:0] pa;
        logic [7:0]  pd;
        exp_q.delete();
        pend = 0;
        pa = '0;
        pd = '0;
        foreach (s_addr[i]) begin
            if (pend && s_addr[i] == pa + 25'd1) begin
                exp_q.push_back({pa[24:1], s_data[i], pd, 2'b11});
                pend = 0;
            end else begin
                if (pend) exp_q.push_back({pa[24:1], 8'h00, pd, 2'b01});
                pend = 0;
                if (s_addr[i][0]) begin
                    exp_q.push_back({s_addr[i][24:1], s_data[i], 8'h00, 2'b10});
                end else begin
                    pend = 1;
                    pa = s_addr[i];
                    pd = s_data[i];
                end
            end
        end
        if (pend) exp_q.push_back({pa[24:1], 8'h00, pd, 2'b01});
    endtask

    task automatic dl_start();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send_strobe(input logic [24:0] a, input logic [7:0] d,
                               input int gap, input bit honor, output bit tmo);
        int n;
        tmo = 0;
        n = 0;
        if (honor) begin
            while (ioctl_wait && n < 200) begin
                tick();
                n++;
            end
            if (ioctl_wait) tmo = 1;
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic dl_finish(output bit ds, output bit bl, output bit sg);
        ioctl_download = 1'b0;
        ds = 0;
        bl = 0;
        sg = 0;
        for (int i = 0; i < 300 && !ds; i++) begin
            tick();
            if (done) begin
                ds = 1;
                bl = !busy;
                tick();
                sg = !done;
            end
        end
    endtask

    task automatic run_download(input int gap_max, output bit tmo,
                                output bit ds, output bit bl, output bit sg);
        bit t;
        tmo = 0;
        dl_start();
        foreach (s_addr[i]) begin
            send_strobe(s_addr[i], s_data[i], $urandom_range(2, gap_max), 1, t);
            tmo |= t;
        end
        dl_finish(ds, bl, sg);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, busy, done, overflow, ioctl_wait} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {mem_req, busy, done, overflow, ioctl_wait});
        end
        n_checks++;
        if (byte_count !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_byte_count: got %0h expected 0", byte_count);
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_be} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_mem_port: got %0h expected 0", {mem_addr, mem_wdata, mem_be});
        end
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_full_word();
        bit tmo, ds, bl, sg;
        int base;
        auto_en = 1;
        ack_max = 0;
        base = rx_q.size();
        s_addr = '{25'h150000, 25'h150001};
        s_data = '{8'h11, 8'h22};
        run_download(3, tmo, ds, bl, sg);
        n_checks++;
        if ({tmo, ds, bl, sg} !== 4'b0111) begin
            n_fail++;
            $display("FAIL full_word_done: got tmo/done/busylow/single=%b expected 0111", {tmo, ds, bl, sg});
        end
        n_checks++;
        if (rx_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL full_word_count: got %0d expected 1", rx_q.size() - base);
        end else begin
            n_checks++;
            if (rx_q[base] !== {24'h0A8000, 16'h2211, 2'b11}) begin
                n_fail++;
                $display("FAIL full_word_data: got %0h expected %0h", rx_q[base], {24'h0A8000, 16'h2211, 2'b11});
            end
        end
        n_checks++;
        if (byte_count !== 25'd2) begin
            n_fail++;
            $display("FAIL full_word_byte_count: got %0d expected 2", byte_count);
        end
    endtask

    task automatic test_split_word();
        bit tmo, ds, bl, sg;
        int base;
        auto_en = 1;
        ack_max = 1;
        base = rx_q.size();
        s_addr = '{25'h000004, 25'h000007};
        s_data = '{8'h11, 8'h22};
        run_download(4, tmo, ds, bl, sg);
        n_checks++;
        if ({tmo, ds, bl, sg} !== 4'b0111) begin
            n_fail++;
            $display("FAIL split_done: got tmo/done/busylow/single=%b expected 0111", {tmo, ds, bl, sg});
        end
        n_checks++;
        if (rx_q.size() - base !== 2) begin
            n_fail++;
            $display("FAIL split_count: got %0d expected 2", rx_q.size() - base);
        end else begin
            n_checks++;
            if (rx_q[base] !== {24'h000002, 16'h0011, 2'b01}) begin
                n_fail++;
                $display("FAIL split_first: got %0h expected %0h", rx_q[base], {24'h000002, 16'h0011, 2'b01});
            end
            n_checks++;
            if (rx_q[base+1] !== {24'h000003, 16'h2200, 2'b10}) begin
                n_fail++;
                $display("FAIL split_second: got %0h expected %0h", rx_q[base+1], {24'h000003, 16'h2200, 2'b10});
            end
        end
    endtask

    task automatic test_partial_end();
        bit tmo, early, ds;
        auto_en = 0;
        early = 0;
        ds = 0;
        dl_start();
        send_strobe(25'h000010, 8'h5A, 2, 0, tmo);
        ioctl_download = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            early |= done;
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_early_done: got done=1 before ack expected 0");
        end
        n_checks++;
        if ({mem_req, mem_addr, mem_wdata, mem_be} !== {1'b1, 24'h000008, 16'h005A, 2'b01}) begin
            n_fail++;
            $display("FAIL partial_word: got %0h expected %0h", {mem_req, mem_addr, mem_wdata, mem_be},
                     {1'b1, 24'h000008, 16'h005A, 2'b01});
        end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        for (int i = 0; i < 20 && !ds; i++) begin
            if (done) ds = 1;
            else tick();
        end
        n_checks++;
        if (ds !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_done: got done=%b busy=%b expected 1 0", ds, busy);
        end
        tick();
    endtask

    task automatic test_overflow();
        bit          tmo, ds, bl, sg;
        logic [41:0] got[$];
        logic [41:0] expw[$];
        int          k, occ;
        auto_en = 0;
        s_addr.delete();
        s_data.delete();
        for (int i = 0; i < 14; i++) begin
            s_addr.push_back(25'h000200 + 25'(i));
            s_data.push_back(8'($urandom));
        end
        model_words();
        dl_start();
        for (int i = 0; i < 12; i++) begin
            send_strobe(s_addr[i], s_data[i], 2, 0, tmo);
            if (i % 2 == 1) begin
                k = (i + 1) / 2;
                occ = (k < 4) ? k : 4;
                n_checks++;
                if (ioctl_wait !== (occ >= 3)) begin
                    n_fail++;
                    $display("FAIL wait_level word %0d: got %b expected %b", k, ioctl_wait, occ >= 3);
                end
                if (k == 4) begin
                    n_checks++;
                    if (overflow !== 1'b0) begin
                        n_fail++;
                        $display("FAIL overflow_early: got %b expected 0", overflow);
                    end
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        send_strobe(s_addr[12], s_data[12], 2, 0, tmo);
        // completing word 7 while acking the head: push and pop together
        got.push_back({mem_addr, mem_wdata, mem_be});
        ioctl_addr = s_addr[13];
        ioctl_dout = s_data[13];
        ioctl_wr = 1'b1;
        man_ack = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        man_ack = 1'b0;
        tick();
        n_checks++;
        if ({mem_req, ioctl_wait} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_push_pop: got req/wait=%b expected 11", {mem_req, ioctl_wait});
        end
        for (int i = 0; i < 10 && mem_req; i++) begin
            got.push_back({mem_addr, mem_wdata, mem_be});
            man_ack = 1'b1;
            tick();
            man_ack = 1'b0;
        end
        // words 5 and 6 arrived while the FIFO held four unacked words
        expw = exp_q;
        expw.delete(5);
        expw.delete(4);
        n_checks++;
        if (got.size() !== expw.size()) begin
            n_fail++;
            $display("FAIL overflow_word_count: got %0d expected %0d", got.size(), expw.size());
        end else begin
            foreach (expw[i]) begin
                n_checks++;
                if (got[i] !== expw[i]) begin
                    n_fail++;
                    $display("FAIL overflow_word %0d: got %0h expected %0h", i, got[i], expw[i]);
                end
            end
        end
        n_checks++;
        if (byte_count !== 25'd14) begin
            n_fail++;
            $display("FAIL overflow_byte_count: got %0d expected 14", byte_count);
        end
        dl_finish(ds, bl, sg);
        n_checks++;
        if ({ds, bl, sg} !== 3'b111) begin
            n_fail++;
            $display("FAIL overflow_done: got done/busylow/single=%b expected 111", {ds, bl, sg});
        end
    endtask

    task automatic test_reset_mid();
        bit tmo, ds, bl, sg, seen;
        int base;
        auto_en = 0;
        dl_start();
        for (int i = 0; i < 7; i++) send_strobe(25'h000100 + 25'(i), 8'(i + 1), 2, 0, tmo);
        n_checks++;
        if ({mem_req, byte_count} !== {1'b1, 25'd7}) begin
            n_fail++;
            $display("FAIL pre_reset_state: got req=%b count=%0d expected 1 7", mem_req, byte_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({mem_req, busy, ioctl_wait, overflow, byte_count} !== 29'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got req=%b busy=%b wait=%b ovf=%b count=%0d expected all 0",
                     mem_req, busy, ioctl_wait, overflow, byte_count);
        end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        n_checks++;
        if ({mem_req, ioctl_wait} !== 2'b00) begin
            n_fail++;
            $display("FAIL late_ack: got req/wait=%b expected 00", {mem_req, ioctl_wait});
        end
        // download still high after reset: no new download until a fresh rise
        send_strobe(25'h000200, 8'h77, 2, 0, tmo);
        n_checks++;
        if ({busy, mem_req, byte_count} !== 27'd0) begin
            n_fail++;
            $display("FAIL no_rise_after_reset: got busy=%b req=%b count=%0d expected 0 0 0",
                     busy, mem_req, byte_count);
        end
        ioctl_download = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= done;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_done: got done=1 expected 0");
        end
        auto_en = 1;
        ack_max = 2;
        base = rx_q.size();
        s_addr = '{25'h000300, 25'h000301};
        s_data = '{8'hA1, 8'hB2};
        run_download(3, tmo, ds, bl, sg);
        n_checks++;
        if (rx_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL fresh_count: got %0d expected 1", rx_q.size() - base);
        end else begin
            n_checks++;
            if (rx_q[base] !== {24'h000180, 16'hB2A1, 2'b11}) begin
                n_fail++;
                $display("FAIL fresh_word: got %0h expected %0h", rx_q[base], {24'h000180, 16'hB2A1, 2'b11});
            end
        end
    endtask

    task automatic test_random();
        bit          tmo, ds, bl, sg;
        int          base, n;
        logic [24:0] a;
        auto_en = 1;
        for (int it = 0; it < 5; it++) begin
            ack_max = it % 4;
            s_addr.delete();
            s_data.delete();
            n = $urandom_range(4, 18);
            a = 25'($urandom);
            for (int i = 0; i < n; i++) begin
                if (i != 0) begin
                    if ($urandom_range(0, 3) == 0) a = 25'($urandom);
                    else a = a + 25'd1;
                end
                s_addr.push_back(a);
                s_data.push_back(8'($urandom));
            end
            model_words();
            base = rx_q.size();
            run_download(5, tmo, ds, bl, sg);
            n_checks++;
            if ({tmo, ds, bl, sg, overflow} !== 5'b01110) begin
                n_fail++;
                $display("FAIL rand%0d_status: got tmo/done/busylow/single/ovf=%b expected 01110",
                         it, {tmo, ds, bl, sg, overflow});
            end
            n_checks++;
            if (byte_count !== 25'(n)) begin
                n_fail++;
                $display("FAIL rand%0d_byte_count: got %0d expected %0d", it, byte_count, n);
            end
            n_checks++;
            if (rx_q.size() - base !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_word_count: got %0d expected %0d", it, rx_q.size() - base, exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (rx_q[base+i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_word %0d: got %0h expected %0h", it, i, rx_q[base+i], exp_q[i]);
                    end
                end
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_split_word();
        test_partial_end();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
